// File: rtl/d2b_pkg.sv
// Shared definitions for the decimal-to-binary game number path.
package d2b_pkg;

  localparam int NUM_W     = 10;
  localparam int LEVEL_W   = 4;
  localparam int MAX_LEVEL = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ASK,
    CHECK,
    RESULT,
    DONE
  } judge_state_t;

  // Low 'lvl' bits set; any level at or above NUM_W yields all ones.
  function automatic logic [NUM_W-1:0] level_mask(input logic [LEVEL_W-1:0] lvl);
    logic [NUM_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_W; i++) begin
      if (i < int'(lvl)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/d2b_round_timer.sv
// Clear/enable down-counter. After clear, expire rises on the CYCLES-th
// enabled cycle and holds until the next clear.
module d2b_round_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Reload on clear, count down while enabled, park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clear)                cnt <= CW'(CYCLES - 1);
    else if (enable && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/d2b_round_judge.sv
// Round sequencer and answer judge for the decimal-to-binary game.
// Optional feature: define D2B_ROUND_TIMEOUT_EN to give each round an
// answer window of ROUND_CYCLES; otherwise ASK waits for submit forever.
module d2b_round_judge
  import d2b_pkg::*;
#(
  parameter int LIVES             = 3,
  parameter int CORRECT_PER_LEVEL = 3,
  parameter int ROUND_CYCLES      = 500_000_000,
  parameter int RESULT_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       submit,
  input  logic [9:0] sw,
  input  logic [9:0] rng_num,
  output logic [3:0] level,
  output logic [9:0] shown_num,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       result_valid,
  output logic       result_ok,
  output logic       game_over,
  output logic       won
);

  judge_state_t state, state_nx;
  logic [3:0]   streak;
  logic         timed_out;
  logic         round_exp;
  logic         res_exp;
  logic         ok_now;

  // A timed-out round is wrong whatever the switches show.
  assign ok_now = (sw == shown_num) && !timed_out;

`ifdef D2B_ROUND_TIMEOUT_EN
  d2b_round_timer #(.CYCLES(ROUND_CYCLES)) u_round_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == LOAD),
    .enable (state == ASK),
    .expire (round_exp)
  );
`else
  // No answer window: never expires (ROUND_CYCLES is always positive).
  assign round_exp = (ROUND_CYCLES < 0);
`endif

  d2b_round_timer #(.CYCLES(RESULT_CYCLES)) u_result_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == CHECK),
    .enable (state == RESULT),
    .expire (res_exp)
  );

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = ASK;
      ASK:     if (submit || round_exp) state_nx = CHECK;
      CHECK:   state_nx = RESULT;
      RESULT:  if (res_exp) state_nx = (won || lives == 2'd0) ? DONE : LOAD;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // State, round data and score/lives/level bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      level        <= 4'd1;
      shown_num    <= '0;
      score        <= '0;
      lives        <= 2'(LIVES);
      streak       <= '0;
      timed_out    <= 1'b0;
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      game_over    <= 1'b0;
      won          <= 1'b0;
    end else begin
      state        <= state_nx;
      result_valid <= (state == ASK) && (state_nx == CHECK);
      game_over    <= (state_nx == DONE);
      case (state)
        IDLE, DONE: if (start) begin
          level     <= 4'd1;
          score     <= '0;
          lives     <= 2'(LIVES);
          streak    <= '0;
          won       <= 1'b0;
          result_ok <= 1'b0;
        end
        LOAD: begin
          shown_num <= rng_num & level_mask(level);
          timed_out <= 1'b0;
        end
        ASK: if (!submit && round_exp) timed_out <= 1'b1;
        CHECK: begin
          result_ok <= ok_now;
          if (ok_now) begin
            if (score != 8'hFF) score <= score + 8'd1;
            if (streak == 4'(CORRECT_PER_LEVEL - 1)) begin
              streak <= '0;
              if (level == 4'(MAX_LEVEL)) won <= 1'b1;
              else                        level <= level + 4'd1;
            end else begin
              streak <= streak + 4'd1;
            end
          end else begin
            streak <= '0;
            if (lives != 2'd0) lives <= lives - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d2b_round_judge.sv
// Directed bench for d2b_round_judge; expected values come from a small
// behavioural model of the game rules.
module tb_d2b_round_judge;

  localparam int LIVES = 2;
  localparam int CPL   = 2;
  localparam int RC    = 8;
  localparam int RES   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [9:0] sw = '0;
  logic [9:0] rng_num = '0;
  logic [3:0] level;
  logic [9:0] shown_num;
  logic [7:0] score;
  logic [1:0] lives;
  logic       result_valid, result_ok, game_over, won;

  int checks = 0;
  int failures = 0;
  int m_level, m_score, m_lives, m_streak;
  bit m_won;

  always #5 clk = ~clk;

  d2b_round_judge #(
    .LIVES(LIVES), .CORRECT_PER_LEVEL(CPL),
    .ROUND_CYCLES(RC), .RESULT_CYCLES(RES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .submit(submit),
    .sw(sw), .rng_num(rng_num), .level(level), .shown_num(shown_num),
    .score(score), .lives(lives), .result_valid(result_valid),
    .result_ok(result_ok), .game_over(game_over), .won(won)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_mask(input int lvl);
    logic [10:0] one;
    one = 11'd1;
    return (lvl >= 10) ? 10'h3FF : 10'((one << lvl) - 11'd1);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, level, 1);
    check({tag, "_shown"}, shown_num, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_lives"}, lives, LIVES);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_ok"}, result_ok, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_won"}, won, 0);
  endtask

  task automatic model_verdict(input bit ok);
    if (ok) begin
      if (m_score < 255) m_score++;
      m_streak++;
      if (m_streak == CPL) begin
        m_streak = 0;
        if (m_level == 10) m_won = 1;
        else m_level++;
      end
    end else begin
      m_streak = 0;
      if (m_lives > 0) m_lives--;
    end
  endtask

  // Start pulse from IDLE/DONE; returns in the first ASK cycle.
  task automatic begin_game();
    start = 1'b1; tick(); start = 1'b0;
    m_level = 1; m_score = 0; m_lives = LIVES; m_streak = 0; m_won = 0;
    check("start_level", level, 1);
    check("start_score", score, 0);
    check("start_lives", lives, LIVES);
    check("start_over", game_over, 0);
    check("start_won", won, 0);
    tick();
  endtask

  // Called in the first RESULT cycle; returns in the next ASK cycle or in DONE.
  task automatic finish_result();
    repeat (RES - 1) tick();
    check("result_hold_over", game_over, 0);
    tick();
    if (m_won || m_lives == 0) begin
      check("done_over", game_over, 1);
      check("done_won", won, m_won);
      check("done_level", level, m_level);
    end else begin
      tick();
    end
  endtask

  task automatic check_verdict(input string tag, input bit ok);
    check({tag, "_valid_drop"}, result_valid, 0);
    check({tag, "_ok"}, result_ok, ok);
    check({tag, "_score"}, score, m_score);
    check({tag, "_level"}, level, m_level);
    check({tag, "_lives"}, lives, m_lives);
    check({tag, "_won"}, won, m_won);
  endtask

  // One round answered on the first ASK cycle.
  task automatic play(input bit correct);
    logic [9:0] exp_shown;
    exp_shown = rng_num & exp_mask(m_level);
    check("shown_num", shown_num, exp_shown);
    sw = correct ? exp_shown : (exp_shown ^ 10'h001);
    submit = 1'b1; tick(); submit = 1'b0;
    check("valid_pulse", result_valid, 1);
    tick();
    model_verdict(correct);
    check_verdict("round", correct);
    rng_num = 10'((rng_num * 10'd37 + 10'd101) & 10'h3FF);
    finish_result();
  endtask

  initial begin
    logic [9:0] exp_shown;
    rng_num = 10'h3FF;
    tick(); tick();
    check_reset_values("in_reset");
    rst_n = 1'b1;
    tick();
    check_reset_values("after_reset");

    // submit in IDLE is ignored
    submit = 1'b1; tick(); submit = 1'b0;
    check("idle_submit_valid", result_valid, 0);
    tick();
    check("idle_submit_score", score, 0);

    // game 1: first round shows 0x001, level advance after two, then lose
    begin_game();
    check("first_shown", shown_num, 10'h001);
    play(1'b1);
    play(1'b1);
    play(1'b1);
    play(1'b1);
    play(1'b0);
    play(1'b0);
    check("lost_over", game_over, 1);
    check("lost_won", won, 0);

    // submit ignored in DONE
    submit = 1'b1; tick(); submit = 1'b0;
    check("done_submit_valid", result_valid, 0);
    tick();
    check("done_submit_over", game_over, 1);

    // game 2: clear all ten levels
    begin_game();
    for (int r = 0; r < 10 * CPL; r++) play(1'b1);
    check("win_over", game_over, 1);
    check("win_won", won, 1);
    check("win_level", level, 10);
    check("win_score", score, 10 * CPL);

    // game 3: answer window, then reset mid-round
    begin_game();
`ifdef D2B_ROUND_TIMEOUT_EN
    exp_shown = rng_num & exp_mask(m_level);
    sw = exp_shown;
    for (int k = 1; k < RC; k++) begin
      tick();
      check("no_early_verdict", result_valid, 0);
    end
    tick();
    check("timeout_valid", result_valid, 1);
    tick();
    model_verdict(1'b0);
    check_verdict("timeout", 1'b0);
    finish_result();
    // submit on the expiring cycle is judged normally
    exp_shown = rng_num & exp_mask(m_level);
    check("expire_shown", shown_num, exp_shown);
    sw = exp_shown;
    repeat (RC - 1) tick();
    submit = 1'b1; tick(); submit = 1'b0;
    check("expire_submit_valid", result_valid, 1);
    tick();
    model_verdict(1'b1);
    check_verdict("expire_submit", 1'b1);
    finish_result();
`else
    repeat (3 * RC) tick();
    check("no_timeout_valid", result_valid, 0);
    check("no_timeout_lives", lives, LIVES);
    play(1'b1);
`endif

    // asynchronous reset in the middle of ASK
    exp_shown = rng_num & exp_mask(m_level);
    sw = exp_shown;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick();
    rst_n = 1'b1;
    submit = 1'b1; tick(); submit = 1'b0;
    check("post_reset_submit_valid", result_valid, 0);
    tick();
    check("post_reset_score", score, 0);
    check("post_reset_over", game_over, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
